controle_de_busca: RTL and testbench
====================================

// Module: controle_de_busca
// PURPOSE
//  Program-counter sequencer for the single-cycle iZero core. Drives the instruction ROM address each cycle.
//  Decodes control-flow opcodes (j, jal, jf, jr, in, halt) and gates datapath commit.
//  Stalls on IN until the input device is valid. Freezes the core on HALT or on an out-of-range PC.
// PARAMETERS
//  MEM_SIZE  150  instruction ROM depth in words; any PC >= MEM_SIZE is illegal
// PORTS
//  clock           in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  instrucao       in   32  current instruction word read from ROM at pc
//  dado_rs         in   32  register-file value of field rs (jf condition / jr target)
//  entrada_valida  in   1   input device holds a valid value for IN
//  passo           in   1   single-step advance pulse (present only with IZERO_SINGLE_STEP_EN)
//  pc              out  26  current instruction address (registered)
//  link            out  26  pc+1, written to $31 by jal
//  escreve_hab     out  1   datapath commit: reg/mem writes may occur at this clock edge
//  entrada_aceita  out  1   one-cycle pulse: IN value consumed this edge
//  saida_valida    out  1   one-cycle pulse: OUT instruction committing this edge
//  parado          out  1   core halted (HALT executed or PC error)
//  erro_pc         out  1   sticky: next PC computed out of range
// BEHAVIOUR
//  - Opcodes use instrucao[31:26]:
//      j=010110, jal=010111, jf=010101, in=010011, out=010100, halt=011000.
//    R-type (000000) with funct instrucao[5:0]=010010 is jr. All other opcodes are sequential.
//  - States: EXEC, ESPERA_IN, PARADO. The state register, pc and erro_pc are the only registers.
//  - Reset (reset=0, async): pc=0, state=EXEC, erro_pc=0.
//    While reset is asserted, escreve_hab, entrada_aceita and saida_valida are 0.
//  - All other outputs are combinational from state, pc and instrucao, valid within the same cycle.
//  - Next PC in EXEC:
//      j / jal: instrucao[25:0]
//      jf: instrucao[15:0] zero-extended if dado_rs==0, else pc+1
//      jr: dado_rs[25:0]
//      all others: pc+1
//  - link = pc+1 in every cycle. Arithmetic is 26-bit unsigned with no wrap;
//    pc+1 at pc=MEM_SIZE-1 is an out-of-range error.
//  - EXEC, ordinary instruction: escreve_hab=1, pc<=next.
//  - EXEC, out: additionally saida_valida=1 in that cycle.
//  - EXEC, in:
//      entrada_valida=1: escreve_hab=1, entrada_aceita=1, pc<=pc+1 (zero stall).
//      entrada_valida=0: escreve_hab=0, pc held, ->ESPERA_IN.
//  - ESPERA_IN: escreve_hab=0 and pc held until entrada_valida=1.
//    In that cycle: escreve_hab=1, entrada_aceita=1, pc<=pc+1, ->EXEC.
//  - EXEC, halt: escreve_hab=0, pc held, ->PARADO.
//  - PARADO: parado=1, escreve_hab=0, pc frozen. Exit only through reset.
//  - Out-of-range next PC (>= MEM_SIZE): the current instruction still commits (escreve_hab=1).
//    pc is held, erro_pc<=1, ->PARADO.
//  - Reset asserted mid-stall or while halted returns immediately to pc=0, EXEC.
//    Any pending IN is abandoned with no acceptance pulse.
// CONFIGURATION
//  IZERO_SINGLE_STEP_EN defined:
//    - The passo port exists.
//    - In EXEC, commit and pc update happen only in cycles where passo=1.
//      Otherwise escreve_hab=0, pc held, and no pulse outputs fire.
//    - ESPERA_IN requires entrada_valida=1 and passo=1 in the same cycle.
//    - passo is assumed already synchronised and edge-detected to a one-cycle pulse.
//  IZERO_SINGLE_STEP_EN undefined:
//    - No passo port. The core advances every cycle as described above.
// TESTING
//  1. Release reset with ROM[0]=j 30 -> pc=0 during reset, escreve_hab=1; after one edge pc=30.
//  2. jf with dado_rs=0, imm=28 -> pc=28. Repeat with dado_rs=5 at pc=12 -> pc=13.
//  3. in at pc=31, entrada_valida low for 3 cycles, then high:
//       - pc=31 and escreve_hab=0 for 3 cycles;
//       - then entrada_aceita=1 for exactly 1 cycle;
//       - pc=32 next.
//  4. jal at pc=35, target 1 -> link=36 with escreve_hab=1; pc=1 next.
//     Then jr with dado_rs=36 -> pc=36.
//  5. out at pc=40 -> saida_valida=1 for one cycle.
//     halt at pc=41 -> parado=1, pc=41 held for 10 cycles, escreve_hab=0.
//     Pulse reset -> pc=0, parado=0.
//  6. jr with dado_rs=200 and MEM_SIZE=150 -> erro_pc=1, parado=1, pc unchanged.
//     With IZERO_SINGLE_STEP_EN: pc advances only on passo pulses.

Source files
------------

// File: rtl/controle_de_busca.sv
// ---------------------------------------------------------------------------
// controle_de_busca
//   Program-counter sequencer for the single-cycle iZero core. Every cycle it
//   presents the instruction ROM address (pc), decodes the control-flow
//   opcodes (j, jal, jf, jr, in, out, halt) and decides whether the datapath
//   may commit at the next clock edge.
//
//   Optional feature: define IZERO_SINGLE_STEP_EN to add the passo input.
//   When it is defined, the core advances only in cycles where passo=1.
//
// Ports
//   clock           in   1   system clock, rising edge
//   reset           in   1   asynchronous, active-low reset
//   instrucao       in   32  instruction word read from ROM at pc
//   dado_rs         in   32  register value of field rs (jf condition / jr target)
//   entrada_valida  in   1   input device holds a valid value for IN
//   passo           in   1   single-step pulse (IZERO_SINGLE_STEP_EN only)
//   pc              out  26  current instruction address (registered)
//   link            out  26  pc+1, the return address written by jal
//   escreve_hab     out  1   datapath commit enable for this edge
//   entrada_aceita  out  1   IN value consumed at this edge
//   saida_valida    out  1   OUT instruction committing at this edge
//   parado          out  1   core halted (HALT or PC error)
//   erro_pc         out  1   sticky out-of-range PC flag
// ---------------------------------------------------------------------------
module controle_de_busca #(
    parameter int unsigned MEM_SIZE = 150
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic [31:0] dado_rs,
    input  logic        entrada_valida,
`ifdef IZERO_SINGLE_STEP_EN
    input  logic        passo,
`endif
    output logic [25:0] pc,
    output logic [25:0] link,
    output logic        escreve_hab,
    output logic        entrada_aceita,
    output logic        saida_valida,
    output logic        parado,
    output logic        erro_pc
);

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_J     = 6'b010110;
    localparam logic [5:0]  OP_JAL   = 6'b010111;
    localparam logic [5:0]  OP_JF    = 6'b010101;
    localparam logic [5:0]  OP_IN    = 6'b010011;
    localparam logic [5:0]  OP_OUT   = 6'b010100;
    localparam logic [5:0]  OP_HALT  = 6'b011000;
    localparam logic [5:0]  FN_JR    = 6'b010010;
    localparam logic [25:0] LIMITE   = 26'(MEM_SIZE);

    typedef enum logic [1:0] {
        EXEC,
        ESPERA_IN,
        PARADO
    } estado_t;

    estado_t     estado;
    estado_t     estado_prox;
    logic [25:0] pc_prox;
    logic        erro_prox;
    logic [25:0] pc_mais_um;
    logic [25:0] alvo;
    logic [5:0]  opcode;
    logic        eh_in;
    logic        eh_out;
    logic        eh_halt;
    logic        avanca;
    logic        escreve;
    logic        aceita;
    logic        saida;

    assign opcode     = instrucao[31:26];
    assign pc_mais_um = pc + 26'd1;
    assign link       = pc_mais_um;
    assign eh_in      = (opcode == OP_IN);
    assign eh_out     = (opcode == OP_OUT);
    assign eh_halt    = (opcode == OP_HALT);
    assign parado     = (estado == PARADO);

`ifdef IZERO_SINGLE_STEP_EN
    assign avanca = passo;
`else
    assign avanca = 1'b1;
`endif

    // Branch/jump target selection for the instruction currently at pc.
    always_comb begin
        alvo = pc_mais_um;
        case (opcode)
            OP_J, OP_JAL: alvo = instrucao[25:0];
            OP_JF:        alvo = (dado_rs == 32'd0) ? {10'd0, instrucao[15:0]} : pc_mais_um;
            OP_RTYPE:     if (instrucao[5:0] == FN_JR) alvo = dado_rs[25:0];
            default:      alvo = pc_mais_um;
        endcase
    end

    always_comb begin
        estado_prox = estado;
        pc_prox     = pc;
        erro_prox   = erro_pc;
        escreve     = 1'b0;
        aceita      = 1'b0;
        saida       = 1'b0;
        case (estado)
            EXEC: begin
                if (avanca) begin
                    if (eh_halt) begin
                        estado_prox = PARADO;
                    end else if (eh_in && !entrada_valida) begin
                        estado_prox = ESPERA_IN;
                    end else begin
                        // The current instruction commits even when its
                        // successor address is illegal; only pc is frozen.
                        escreve = 1'b1;
                        aceita  = eh_in;
                        saida   = eh_out;
                        if (alvo >= LIMITE) begin
                            erro_prox   = 1'b1;
                            estado_prox = PARADO;
                        end else begin
                            pc_prox = alvo;
                        end
                    end
                end
            end
            ESPERA_IN: begin
                if (entrada_valida && avanca) begin
                    escreve = 1'b1;
                    aceita  = 1'b1;
                    if (pc_mais_um >= LIMITE) begin
                        erro_prox   = 1'b1;
                        estado_prox = PARADO;
                    end else begin
                        pc_prox     = pc_mais_um;
                        estado_prox = EXEC;
                    end
                end
            end
            PARADO: begin
                estado_prox = PARADO;
            end
            default: begin
                estado_prox = PARADO;
            end
        endcase
    end

    // Commit-side pulses are forced low for as long as reset is held, so a
    // reset arriving mid-stall never produces a stray acceptance pulse.
    assign escreve_hab    = escreve & reset;
    assign entrada_aceita = aceita & reset;
    assign saida_valida   = saida & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= EXEC;
            pc      <= 26'd0;
            erro_pc <= 1'b0;
        end else begin
            estado  <= estado_prox;
            pc      <= pc_prox;
            erro_pc <= erro_prox;
        end
    end

endmodule

// File: tb/tb_controle_de_busca.sv
// ---------------------------------------------------------------------------
// tb_controle_de_busca
//   Directed and randomized checks of the iZero PC sequencer against a
//   behavioural model that tracks pc, halted/waiting status and the error
//   flag as plain integers and flags.
// ---------------------------------------------------------------------------
module tb_controle_de_busca;

    localparam int unsigned MEM = 150;

    localparam logic [5:0] OP_J    = 6'b010110;
    localparam logic [5:0] OP_JAL  = 6'b010111;
    localparam logic [5:0] OP_JF   = 6'b010101;
    localparam logic [5:0] OP_IN   = 6'b010011;
    localparam logic [5:0] OP_OUT  = 6'b010100;
    localparam logic [5:0] OP_HALT = 6'b011000;
    localparam logic [5:0] FN_JR   = 6'b010010;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instrucao = 32'd0;
    logic [31:0] dado_rs = 32'd0;
    logic        entrada_valida = 1'b0;
    logic        passo = 1'b1;
    logic [25:0] pc;
    logic [25:0] link;
    logic        escreve_hab;
    logic        entrada_aceita;
    logic        saida_valida;
    logic        parado;
    logic        erro_pc;

    int checks = 0;
    int errors = 0;

    // Reference state
    int unsigned m_pc;
    bit          m_halt;
    bit          m_wait;
    bit          m_err;

    always #5 clock = ~clock;

    controle_de_busca #(.MEM_SIZE(MEM)) dut (
`ifdef IZERO_SINGLE_STEP_EN
        .passo          (passo),
`endif
        .clock          (clock),
        .reset          (reset),
        .instrucao      (instrucao),
        .dado_rs        (dado_rs),
        .entrada_valida (entrada_valida),
        .pc             (pc),
        .link           (link),
        .escreve_hab    (escreve_hab),
        .entrada_aceita (entrada_aceita),
        .saida_valida   (saida_valida),
        .parado         (parado),
        .erro_pc        (erro_pc)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] campo);
        return {op, campo};
    endfunction

    function automatic logic [31:0] mk_jr();
        return {6'b000000, 20'd0, FN_JR};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold reset across one clock edge, checking that pc is cleared and
    // commit outputs stay low; release reset at the following negedge.
    task automatic do_reset(input logic [31:0] ins);
        instrucao      = ins;
        entrada_valida = 1'b1;
        passo          = 1'b1;
        reset          = 1'b0;
        #1;
        m_pc = 0; m_halt = 0; m_wait = 0; m_err = 0;
        chk("rst_pc", 32'(pc), 32'(m_pc));
        chk("rst_escreve_hab", 32'(escreve_hab), 32'd0);
        chk("rst_entrada_aceita", 32'(entrada_aceita), 32'd0);
        chk("rst_saida_valida", 32'(saida_valida), 32'd0);
        chk("rst_parado", 32'(parado), 32'd0);
        chk("rst_erro_pc", 32'(erro_pc), 32'd0);
        @(posedge clock);
        #1;
        chk("rst_pc_hold", 32'(pc), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock cycle: apply inputs (we are just after a negedge), predict,
    // compare before the rising edge, then advance the model.
    task automatic step(input logic [31:0] ins, input logic [31:0] rs,
                        input logic ev, input logic ps);
        logic [5:0]  op;
        bit          adv;
        bit          commit;
        bit          acc;
        bit          sv;
        int unsigned destino;
        int unsigned n_pc;
        bit          n_halt;
        bit          n_wait;
        bit          n_err;

        instrucao      = ins;
        dado_rs        = rs;
        entrada_valida = ev;
        passo          = ps;
`ifdef IZERO_SINGLE_STEP_EN
        adv = ps;
`else
        adv = 1'b1;
`endif
        op = ins[31:26];
        if (op == OP_J || op == OP_JAL)                  destino = ins[25:0];
        else if (op == OP_JF)                            destino = (rs == 0) ? ins[15:0] : m_pc + 1;
        else if (op == 6'd0 && ins[5:0] == FN_JR)        destino = rs[25:0];
        else                                             destino = m_pc + 1;

        commit = 0; acc = 0; sv = 0;
        n_pc = m_pc; n_halt = m_halt; n_wait = m_wait; n_err = m_err;
        if (!m_halt && adv) begin
            if (m_wait) begin
                if (ev) begin
                    commit = 1; acc = 1; destino = m_pc + 1;
                end
            end else if (op == OP_HALT) begin
                n_halt = 1;
            end else if (op == OP_IN && !ev) begin
                n_wait = 1;
            end else begin
                commit = 1;
                acc    = (op == OP_IN);
                sv     = (op == OP_OUT);
            end
            if (commit) begin
                n_wait = 0;
                if (destino >= MEM) begin
                    n_err  = 1;
                    n_halt = 1;
                end else begin
                    n_pc = destino;
                end
            end
        end

        #1;
        chk("pc", 32'(pc), m_pc);
        chk("link", 32'(link), m_pc + 1);
        chk("escreve_hab", 32'(escreve_hab), 32'(commit));
        chk("entrada_aceita", 32'(entrada_aceita), 32'(acc));
        chk("saida_valida", 32'(saida_valida), 32'(sv));
        chk("parado", 32'(parado), 32'(m_halt));
        chk("erro_pc", 32'(erro_pc), 32'(m_err));
        @(posedge clock);
        m_pc = n_pc; m_halt = n_halt; m_wait = n_wait; m_err = n_err;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] rs;
        int          parado_ciclos;

        m_pc = 0; m_halt = 0; m_wait = 0; m_err = 0;
        @(negedge clock);

        // 1: reset with ROM[0] = j 30
        do_reset(mk(OP_J, 26'd30));
        step(mk(OP_J, 26'd30), 32'd0, 1'b0, 1'b1);
        // 2: jf taken / not taken
        step(mk(OP_JF, 26'd28), 32'd0, 1'b0, 1'b1);
        step(mk(OP_J, 26'd12), 32'd0, 1'b0, 1'b1);
        step(mk(OP_JF, 26'd99), 32'd5, 1'b0, 1'b1);
        // 3: in at pc=31 stalls three cycles
        step(mk(OP_J, 26'd31), 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(mk(OP_IN, 26'd0), 32'd0, 1'b0, 1'b1);
        step(mk(OP_IN, 26'd0), 32'd0, 1'b1, 1'b1);
        step(mk(OP_J, 26'd35), 32'd0, 1'b1, 1'b1);
        // 4: jal then jr back through link
        step(mk(OP_JAL, 26'd1), 32'd0, 1'b0, 1'b1);
        step(mk_jr(), 32'd36, 1'b0, 1'b1);
        // zero-stall IN
        step(mk(OP_IN, 26'd0), 32'd0, 1'b1, 1'b1);
        step(mk(OP_J, 26'd40), 32'd0, 1'b0, 1'b1);
        // 5: out, halt, hold, reset
        step(mk(OP_OUT, 26'd0), 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(mk(OP_HALT, 26'd0), 32'd0, 1'b1, 1'b1);
        do_reset(mk(OP_OUT, 26'd0));
        // 6: jr out of range
        step(mk_jr(), 32'd200, 1'b0, 1'b1);
        step(mk(OP_J, 26'd3), 32'd0, 1'b0, 1'b1);
        step(mk(OP_J, 26'd3), 32'd0, 1'b0, 1'b1);
        do_reset(mk(OP_IN, 26'd0));
        // sequential fall-off at the last ROM word, via an IN
        step(mk(OP_J, 26'd149), 32'd0, 1'b0, 1'b1);
        step(mk(OP_IN, 26'd0), 32'd0, 1'b0, 1'b1);
        step(mk(OP_IN, 26'd0), 32'd0, 1'b1, 1'b1);
        step(mk(OP_J, 26'd3), 32'd0, 1'b0, 1'b1);
        // reset in the middle of an IN stall
        do_reset(mk(OP_IN, 26'd0));
        step(mk(OP_IN, 26'd0), 32'd0, 1'b0, 1'b1);
        step(mk(OP_IN, 26'd0), 32'd0, 1'b0, 1'b1);
        do_reset(mk(OP_IN, 26'd0));
        step(mk(OP_IN, 26'd0), 32'd0, 1'b1, 1'b1);
        // passo low: core must idle only when single-step is built in
        step(mk(OP_J, 26'd7), 32'd0, 1'b0, 1'b0);
        step(mk(OP_OUT, 26'd0), 32'd0, 1'b0, 1'b0);
        step(mk(OP_J, 26'd7), 32'd0, 1'b0, 1'b1);

        // Randomized program
        parado_ciclos = 0;
        for (int n = 0; n < 400; n++) begin
            rs = 32'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 170));
            case ($urandom_range(0, 9))
                0:       ins = mk(OP_J,   26'($urandom_range(0, 160)));
                1:       ins = mk(OP_JAL, 26'($urandom_range(0, 155)));
                2:       ins = mk(OP_JF,  26'($urandom_range(0, 160)));
                3:       ins = mk_jr();
                4, 5:    ins = mk(OP_IN,  26'($urandom));
                6:       ins = mk(OP_OUT, 26'($urandom));
                7:       ins = ($urandom_range(0, 4) == 0) ? mk(OP_HALT, 26'd0) : mk(6'b001000, 26'($urandom));
                8:       ins = {6'b000000, 20'($urandom), 6'b100000};
                default: ins = mk(6'b100011, 26'($urandom));
            endcase
            step(ins, rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            if (m_halt) parado_ciclos++;
            if (parado_ciclos > 2) begin
                parado_ciclos = 0;
                do_reset(mk(OP_OUT, 26'd0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
